// File: rtl/epoch_sequencer_if.sv
// rtl/epoch_sequencer_if.sv - request/completion handshake between sequencer and phase controller
interface epoch_sequencer_if #(
  parameter int ADDR_W = 8
);
  logic              TR;
  logic              VL;
  logic              S_Train;
  logic              S_Error;
  logic              miss_in;
  logic [ADDR_W-1:0] sample_addr;

  modport master (output TR, VL, sample_addr, input S_Train, S_Error, miss_in);
  modport slave  (input TR, VL, sample_addr, output S_Train, S_Error, miss_in);
endinterface

// File: rtl/epoch_sequencer.sv
// rtl/epoch_sequencer.sv - walks training then validation samples per epoch,
// counts validation misses and guards each outstanding request with a watchdog
module epoch_sequencer #(
  parameter int N_TRAIN = 16,
  parameter int N_VAL   = 4,
  parameter int N_EPOCH = 8,
  parameter int ADDR_W  = 8,
  parameter int EPOCH_W = 8,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 127,
  parameter int WD_W    = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  epoch_sequencer_if.master  bus,
  output logic [EPOCH_W-1:0] epoch,
  output logic [CNT_W-1:0]   epoch_miss,
  output logic               busy,
  output logic               done,
  output logic               timeout_err
);

  typedef enum logic [2:0] {
    IDLE, TR_ISSUE, TR_WAIT, VL_ISSUE, VL_WAIT, EPOCH_END, DONE, FAULT
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  addr_d;
  logic [EPOCH_W-1:0] epoch_d;
  logic [CNT_W-1:0]   run_q, run_d, emiss_d;
  logic [WD_W-1:0]    wd_q, wd_d;
  logic               done_d, terr_d;
  logic               active;
  logic               wd_expire;

  assign active    = (state_q != IDLE) && (state_q != FAULT);
  assign wd_expire = (wd_q == WD_W'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    addr_d  = bus.sample_addr;
    epoch_d = epoch;
    run_d   = run_q;
    emiss_d = epoch_miss;
    wd_d    = wd_q;
    done_d  = done;
    terr_d  = timeout_err;
    // abort freezes every counter and drops the outstanding request
    if (abort && active) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (start) begin
          state_d = TR_ISSUE;
          addr_d  = '0;
          epoch_d = '0;
          run_d   = '0;
          emiss_d = '0;
          done_d  = 1'b0;
          terr_d  = 1'b0;
        end
        TR_ISSUE: begin
          wd_d    = '0;
          state_d = TR_WAIT;
        end
        TR_WAIT: begin
          wd_d = wd_q + 1'b1;
          if (bus.S_Train) begin
            if (bus.sample_addr == ADDR_W'(N_TRAIN - 1)) begin
              addr_d  = '0;
              state_d = (N_VAL == 0) ? EPOCH_END : VL_ISSUE;
            end else begin
              addr_d  = bus.sample_addr + 1'b1;
              state_d = TR_ISSUE;
            end
          end else if (wd_expire) begin
            state_d = FAULT;
            terr_d  = 1'b1;
          end
        end
        VL_ISSUE: begin
          wd_d    = '0;
          state_d = VL_WAIT;
        end
        VL_WAIT: begin
          wd_d = wd_q + 1'b1;
          if (bus.S_Error) begin
            run_d = (run_q == '1) ? run_q : run_q + CNT_W'(bus.miss_in);
            if (bus.sample_addr == ADDR_W'(N_VAL - 1)) begin
              addr_d  = '0;
              state_d = EPOCH_END;
            end else begin
              addr_d  = bus.sample_addr + 1'b1;
              state_d = VL_ISSUE;
            end
          end else if (wd_expire) begin
            state_d = FAULT;
            terr_d  = 1'b1;
          end
        end
        EPOCH_END: begin
          emiss_d = run_q;
          run_d   = '0;
          if (epoch == EPOCH_W'(N_EPOCH - 1)) begin
            state_d = DONE;
          end else begin
            epoch_d = epoch + 1'b1;
            state_d = TR_ISSUE;
          end
        end
        DONE: begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
        FAULT: state_d = FAULT;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      bus.TR          <= 1'b0;
      bus.VL          <= 1'b0;
      bus.sample_addr <= '0;
      epoch           <= '0;
      epoch_miss      <= '0;
      run_q           <= '0;
      wd_q            <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      timeout_err     <= 1'b0;
    end else begin
      state_q         <= state_d;
      bus.TR          <= (state_d == TR_ISSUE);
      bus.VL          <= (state_d == VL_ISSUE);
      bus.sample_addr <= addr_d;
      epoch           <= epoch_d;
      epoch_miss      <= emiss_d;
      run_q           <= run_d;
      wd_q            <= wd_d;
      busy            <= (state_d != IDLE) && (state_d != FAULT);
      done            <= done_d;
      timeout_err     <= terr_d;
    end
  end

endmodule

// File: doc/epoch_sequencer.md
Name: epoch_sequencer

Overview:
- Initiator side of the training/validation phase-control handshake: drives the one-cycle TR/VL request pulses and consumes the S_Train/S_Error completion pulses returned by the phase controller.
- Walks the training sample set, then the validation sample set, for a programmed number of epochs. Presents the current sample address to the sample memories.
- Accumulates per-epoch validation misses and guards every request with a watchdog.

Parameters:
- N_TRAIN, 16, training samples per epoch (>=1)
- N_VAL, 4, validation samples per epoch (>=0; 0 skips validation)
- N_EPOCH, 8, epochs per run (>=1)
- ADDR_W, 8, sample_addr width (2^ADDR_W >= max(N_TRAIN,N_VAL))
- EPOCH_W, 8, epoch counter width
- CNT_W, 8, miss counter width
- TIMEOUT, 127, max cycles waiting for a completion pulse
- WD_W, 7, watchdog width (2^WD_W-1 >= TIMEOUT)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin run; sampled only in IDLE
- abort  in  1  cancel run; returns to IDLE without done
- S_Train  in  1  training-sample-complete pulse from controller
- S_Error  in  1  validation-sample-complete pulse from controller
- miss_in  in  1  validation result for the current sample; 1 = miss; sampled with S_Error
- TR  out  1  training request pulse
- VL  out  1  validation request pulse
- sample_addr  out  ADDR_W  index of the current sample
- epoch  out  EPOCH_W  current epoch index
- epoch_miss  out  CNT_W  miss count of the last completed epoch
- busy  out  1  run in progress
- done  out  1  run completed normally
- timeout_err  out  1  watchdog fired

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high on rst. All registers update on the rising edge of clk; all outputs are registered.
- Reset values: state=IDLE, TR=0, VL=0, sample_addr=0, epoch=0, epoch_miss=0, busy=0, done=0, timeout_err=0. Running miss count and watchdog are also 0.
- rst mid-run aborts immediately; no further TR/VL are issued.
- IDLE:
  - busy=0.
  - start=1 -> TR_ISSUE; clears sample_addr, epoch, running miss, epoch_miss, done and timeout_err.
- TR_ISSUE:
  - TR=1 for exactly one cycle, watchdog=0 -> TR_WAIT.
  - sample_addr is stable from TR_ISSUE until the completion pulse.
- TR_WAIT:
  - Watchdog increments each cycle.
  - S_Train=1 with sample_addr<N_TRAIN-1 -> sample_addr+1, back to TR_ISSUE.
  - S_Train=1 on the last sample -> sample_addr=0, then VL_ISSUE, or EPOCH_END if N_VAL=0.
- VL_ISSUE / VL_WAIT: same as the training pair, using VL and S_Error. On each S_Error, running miss += miss_in, saturating at 2^CNT_W-1. The last sample -> sample_addr=0, then EPOCH_END.
- EPOCH_END (1 cycle):
  - epoch_miss <= running miss (including a miss_in captured in the same final cycle); running miss <= 0.
  - If epoch==N_EPOCH-1 -> DONE, else epoch+1 -> TR_ISSUE.
- DONE (1 cycle): done <= 1 -> IDLE. done stays high in IDLE until the next accepted start.
- Watchdog: watchdog reaching TIMEOUT in TR_WAIT/VL_WAIT before the expected pulse -> FAULT. A completion pulse arriving in the same cycle as TIMEOUT wins.
- FAULT: timeout_err=1, busy=0, sticky. Only rst exits; start and abort are ignored.
- Request spacing: at most one request outstanding; TR and VL are never both high. A new request is never issued in the cycle of its completion pulse; minimum request-to-request spacing is 2 cycles.
- Stray pulses:
  - S_Train is ignored outside TR_WAIT; S_Error is ignored outside VL_WAIT.
  - The wrong-type pulse in a WAIT state is ignored and does not reset the watchdog.
- abort:
  - In any state other than IDLE/FAULT -> IDLE next cycle; done stays 0, counters freeze, the outstanding request is abandoned.
  - abort beats a simultaneous completion pulse.
- busy: 1 in every state except IDLE and FAULT.
- start while busy is ignored.

Test Plan:
- Normal run: N_TRAIN=2, N_VAL=1, N_EPOCH=2; responder answers TR after 56 cycles and VL after 22 -> TR pulses at sample_addr 0,1, then a VL at 0, per epoch. done=1 after the second EPOCH_END; 4 TR and 2 VL pulses total, each 1 cycle wide.
- Miss accounting: miss_in=1 on both validation responses of epoch 0 with N_VAL=2, 0 in epoch 1 -> epoch_miss=2 after epoch 0, 0 after epoch 1. Also force 300 misses with CNT_W=8 -> saturates at 255.
- Timeout: responder never answers the first TR, TIMEOUT=127 -> timeout_err=1 and busy=0 at the 127th wait cycle. start is then ignored; rst clears everything.
- Race: S_Train arrives in the exact TIMEOUT cycle -> no fault, next TR issued. abort coincident with S_Train -> IDLE, done=0, no further TR.
- Stray and invalid inputs: S_Error during TR_WAIT, S_Train while IDLE, start while busy -> no state, counter or watchdog change.
- Reset mid-run: rst during VL_WAIT of epoch 1 -> all outputs return to reset values next cycle; a fresh start runs the full 2-epoch sequence from sample 0.
